// File: rtl/sram_data_ctrl.sv
// MEM-stage data port: one 32-bit word access served as two 16-bit async SRAM phases.
// Latency 2*PHASE_CYCLES+2 cycles per access; ready low from request through the last phase.
module sram_data_ctrl #(
  parameter logic [31:0] BASE_ADDR    = 32'd1024,
  parameter int          SRAM_AW      = 18,
  parameter int          PHASE_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wrEn,
  input  logic               rdEn,
  input  logic [31:0]        address,
  input  logic [31:0]        writeData,
  output logic [31:0]        readData,
  output logic               ready,
  output logic [SRAM_AW-1:0] sramAddr,
  output logic [15:0]        sramDqOut,
  input  logic [15:0]        sramDqIn,
  output logic               sramDqOe,
  output logic               sramWeN,
  output logic               sramOeN
);

  localparam int CW = $clog2(PHASE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(PHASE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic               is_wr;
  logic [SRAM_AW-2:0] word;
  logic [31:0]        data;
  logic [31:0]        offset;
  logic               phase_end;
  logic               unused_offset_bits;

  // Word index keeps only SRAM_AW-1 bits, so offsets wrap silently.
  assign offset             = address - BASE_ADDR;
  assign unused_offset_bits = ^{offset[31:SRAM_AW+1], offset[1:0]};
  assign phase_end          = (cnt == LAST);
  assign ready              = (state == DONE) | ((state == IDLE) & !wrEn & !rdEn);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      is_wr     <= 1'b0;
      word      <= '0;
      data      <= '0;
      readData  <= '0;
      sramAddr  <= '0;
      sramDqOut <= '0;
      sramDqOe  <= 1'b0;
      sramWeN   <= 1'b1;
      sramOeN   <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (wrEn | rdEn) begin
            is_wr     <= wrEn;
            word      <= offset[SRAM_AW:2];
            data      <= writeData;
            cnt       <= '0;
            state     <= LOW;
            // Strobes are set up one edge early so they are clean for the whole phase.
            sramAddr  <= {offset[SRAM_AW:2], 1'b0};
            sramDqOut <= writeData[15:0];
            sramDqOe  <= wrEn;
            sramWeN   <= !wrEn;
            sramOeN   <= wrEn;
          end
        end
        LOW: begin
          if (phase_end) begin
            if (!is_wr) readData[15:0] <= sramDqIn;
            cnt       <= '0;
            state     <= HIGH;
            sramAddr  <= {word, 1'b1};
            sramDqOut <= data[31:16];
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HIGH: begin
          if (phase_end) begin
            if (!is_wr) readData[31:16] <= sramDqIn;
            cnt      <= '0;
            state    <= DONE;
            sramDqOe <= 1'b0;
            sramWeN  <= 1'b1;
            sramOeN  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
